// File: rtl/rtype_core_pkg.sv
// Shared encodings, enums and the instruction decoder for the multi-cycle R-type core.
package rtype_core_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } alu_op_e;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, WB, HALT
  } state_e;

  typedef struct packed {
    logic    legal;
    logic    use_imm;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.legal   = 1'b0;
    d.use_imm = 1'b0;
    d.op      = ADD;
    if (ir[6:0] == OP_IMM && ir[14:12] == F3_ADD) begin
      d.legal   = 1'b1;
      d.use_imm = 1'b1;
    end else if (ir[6:0] == OP_R && ir[31:25] == F7_BASE) begin
      d.legal = 1'b1;
      case (ir[14:12])
        F3_ADD:  d.op = ADD;
        F3_SLL:  d.op = SLL;
        F3_SLT:  d.op = SLT;
        F3_SLTU: d.op = SLTU;
        F3_XOR:  d.op = XOR;
        F3_SR:   d.op = SRL;
        F3_OR:   d.op = OR;
        default: d.op = AND;
      endcase
    end else if (ir[6:0] == OP_R && ir[31:25] == F7_ALT && ir[14:12] == F3_ADD) begin
      d.legal = 1'b1;
      d.op    = SUB;
    end else if (ir[6:0] == OP_R && ir[31:25] == F7_ALT && ir[14:12] == F3_SR) begin
      d.legal = 1'b1;
      d.op    = SRA;
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational ALU for the ten base R-type operations.
module rtype_alu
  import rtype_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ADD:     result_o = a_i + b_i;
      SUB:     result_o = a_i - b_i;
      SLL:     result_o = a_i << shamt;
      SLT:     result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      SLTU:    result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      XOR:     result_o = a_i ^ b_i;
      SRL:     result_o = a_i >> shamt;
      SRA:     result_o = $signed(a_i) >>> shamt;
      OR:      result_o = a_i | b_i;
      AND:     result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_rtype_core.sv
// Four-cycle FETCH/DECODE/EXEC/WB core for RV32I R-type plus ADDI; illegal encodings halt it.
module multicycle_rtype_core
  import rtype_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_WORDS = 64,
  parameter int AW         = $clog2(IMEM_WORDS) + 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  output logic [AW-1:0]   IADDR,
  input  logic [31:0]     INST,
  output logic [XLEN-1:0] OUT,
  output logic            HALTED,
  output logic [31:0]     RETIRED,
  input  logic [4:0]      DBG_SEL,
  output logic [XLEN-1:0] DBG_DATA
);

  localparam int RIW = $clog2(NREG);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q;
  logic [31:0]     ir_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, r_q, out_q;
  logic            halted_q;
  logic [31:0]     retired_q;
  logic [XLEN-1:0] rf_q [NREG];

  dec_t            dec;
  logic [RIW-1:0]  rs1_idx, rs2_idx, rd_idx, dbg_idx;
  logic [XLEN-1:0] imm_sext, alu_res;
  logic            ld_ir, ld_ab, ld_r, do_wb, set_halt;

  assign dec      = decode(ir_q);
  assign rs1_idx  = ir_q[15 +: RIW];
  assign rs2_idx  = ir_q[20 +: RIW];
  assign rd_idx   = ir_q[7 +: RIW];
  assign dbg_idx  = DBG_SEL[RIW-1:0];
  assign imm_sext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

  always_comb begin
    state_d  = state_q;
    ld_ir    = 1'b0;
    ld_ab    = 1'b0;
    ld_r     = 1'b0;
    do_wb    = 1'b0;
    set_halt = 1'b0;
    if (EN) begin
      case (state_q)
        FETCH: begin
          state_d = DECODE;
          ld_ir   = 1'b1;
        end
        DECODE: begin
          if (dec.legal) begin
            state_d = EXEC;
            ld_ab   = 1'b1;
          end else begin
            state_d  = HALT;
            set_halt = 1'b1;
          end
        end
        EXEC: begin
          state_d = WB;
          ld_r    = 1'b1;
        end
        WB: begin
          state_d = FETCH;
          do_wb   = 1'b1;
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= '0;
      ir_q      <= '0;
      op_q      <= ADD;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      out_q     <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (ld_ir) ir_q <= INST;
      if (ld_ab) begin
        a_q  <= rf_q[rs1_idx];
        b_q  <= dec.use_imm ? imm_sext : rf_q[rs2_idx];
        op_q <= dec.op;
      end
      if (set_halt) halted_q <= 1'b1;
      if (ld_r) r_q <= alu_res;
      if (do_wb) begin
        out_q     <= r_q;
        retired_q <= retired_q + 32'd1;
        pc_q      <= pc_q + AW'(4);
      end
    end
  end

  // Entry 0 is never written, so it reads as the hardwired zero register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (do_wb && rd_idx != '0) begin
      rf_q[rd_idx] <= r_q;
    end
  end

  rtype_alu #(.XLEN(XLEN)) u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res)
  );

  assign IADDR    = pc_q;
  assign OUT      = out_q;
  assign HALTED   = halted_q;
  assign RETIRED  = retired_q;
  assign DBG_DATA = (dbg_idx == '0) ? '0 : rf_q[dbg_idx];

endmodule
